// File: rtl/nco_wave_sequencer.sv
// ---------------------------------------------------------------------------
// nco_wave_sequencer
//
// Purpose:
//    Plays a programmable playlist of waveform selects into tt_um_nco. Each
//    playlist slot holds a 4-bit waveform select and a dwell time counted in
//    whole 32-sample NCO periods. A 5-bit phase mirror runs in lock-step with
//    the NCO's free-running LUT address, so select changes are only ever
//    applied on the edge that ends a phase==31 cycle. The NCO output never
//    switches waveform part way through a period.
//
// Ports:
//    clk_50MHz     in   1        system clock, shared with tt_um_nco
//    reset         in   1        asynchronous, active-high, shared with tt_um_nco
//    i_cfg_we      in   1        playlist write strobe (honoured in IDLE only)
//    i_cfg_addr    in   SW       slot index to write
//    i_cfg_sel     in   4        waveform select to store
//    i_cfg_dwell   in   DWELL_W  periods to hold the slot (0 plays as 1)
//    i_cfg_len     in   SW+1     active slot count, sampled on accepted start
//    i_loop        in   1        sampled on accepted start: 1 repeat, 0 one-shot
//    i_start       in   1        begin playback (acted on in IDLE only)
//    i_stop        in   1        request stop (acted on in ARM and RUN)
//    o_signal_out  out  4        select driven to tt_um_nco
//    o_slot_idx    out  SW       slot currently playing
//    o_period_end  out  1        high while the phase mirror is 31
//    o_busy        out  1        high in ARM and RUN
//    o_done        out  1        one-cycle pulse when a sequence ends
// ---------------------------------------------------------------------------
module nco_wave_sequencer #(
   parameter int          NUM_SLOTS = 8,
   parameter int          DWELL_W   = 16,
   parameter logic [3:0]  IDLE_SEL  = 4'd15,
   localparam int         SW        = $clog2(NUM_SLOTS)
) (
   input  logic               clk_50MHz,
   input  logic               reset,
   input  logic               i_cfg_we,
   input  logic [SW-1:0]      i_cfg_addr,
   input  logic [3:0]         i_cfg_sel,
   input  logic [DWELL_W-1:0] i_cfg_dwell,
   input  logic [SW:0]        i_cfg_len,
   input  logic               i_loop,
   input  logic               i_start,
   input  logic               i_stop,
   output logic [3:0]         o_signal_out,
   output logic [SW-1:0]      o_slot_idx,
   output logic               o_period_end,
   output logic               o_busy,
   output logic               o_done
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ARM,
      ST_RUN
   } state_t;

   state_t              r_state;
   logic [4:0]          r_phase;
   logic [3:0]          r_tabSel   [NUM_SLOTS];
   logic [DWELL_W-1:0]  r_tabDwell [NUM_SLOTS];
   logic [SW:0]         r_len;
   logic                r_loop;
   logic [DWELL_W-1:0]  r_dwellCnt;
   logic                r_stopPend;
   logic [3:0]          r_sel;
   logic [SW-1:0]       r_slotIdx;
   logic                r_done;

   state_t              w_stateNext;
   logic [SW:0]         w_lenNext;
   logic                w_loopNext;
   logic [DWELL_W-1:0]  w_dwellNext;
   logic                w_stopPendNext;
   logic [3:0]          w_selNext;
   logic [SW-1:0]       w_slotNext;
   logic                w_doneNext;
   logic                w_tabWe;

   logic                w_periodEnd;
   logic                w_lenOk;
   logic                w_isLast;
   logic [SW-1:0]       w_nextIdx;

   // A zero dwell would otherwise underflow the countdown; it plays as one period.
   function automatic logic [DWELL_W-1:0] dwellEff(input logic [DWELL_W-1:0] d);
      return (d == '0) ? DWELL_W'(1) : d;
   endfunction

   // The phase mirror is held at 0 by reset, so period_end is naturally low
   // then; the explicit gate keeps it low even while reset is still asserted.
   assign w_periodEnd = (r_phase == 5'd31) && !reset;

   // Only lengths from 1 up to the table depth start a sequence.
   assign w_lenOk = (i_cfg_len != '0) && (i_cfg_len <= (SW+1)'(NUM_SLOTS));

   // Last slot of the active playlist when the following index reaches the latched length.
   assign w_isLast  = ((SW+1)'(r_slotIdx) + (SW+1)'(1)) >= r_len;
   assign w_nextIdx = r_slotIdx + SW'(1);

   assign o_signal_out = r_sel;
   assign o_slot_idx   = r_slotIdx;
   assign o_period_end = w_periodEnd;
   assign o_busy       = (r_state != ST_IDLE);
   assign o_done       = r_done;

   // Phase mirror: free-running 5-bit count that matches the NCO LUT address,
   // both restarting from 0 when the shared reset releases.
   always_ff @(posedge clk_50MHz or posedge reset) begin
      if (reset) begin
         r_phase <= 5'd0;
      end else begin
         r_phase <= r_phase + 5'd1;
      end
   end

   // Playlist storage. Writes are gated to IDLE by the control logic so the
   // table cannot change underneath a playing sequence.
   always_ff @(posedge clk_50MHz or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_SLOTS; i++) begin
            r_tabSel[i]   <= 4'd0;
            r_tabDwell[i] <= '0;
         end
      end else if (w_tabWe) begin
         r_tabSel[i_cfg_addr]   <= i_cfg_sel;
         r_tabDwell[i_cfg_addr] <= i_cfg_dwell;
      end
   end

   // Sequencer state register and everything the control process computes.
   always_ff @(posedge clk_50MHz or posedge reset) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_len      <= '0;
         r_loop     <= 1'b0;
         r_dwellCnt <= '0;
         r_stopPend <= 1'b0;
         r_sel      <= IDLE_SEL;
         r_slotIdx  <= '0;
         r_done     <= 1'b0;
      end else begin
         r_state    <= w_stateNext;
         r_len      <= w_lenNext;
         r_loop     <= w_loopNext;
         r_dwellCnt <= w_dwellNext;
         r_stopPend <= w_stopPendNext;
         r_sel      <= w_selNext;
         r_slotIdx  <= w_slotNext;
         r_done     <= w_doneNext;
      end
   end

   // Next-state and datapath control. In RUN every decision is taken only on
   // a period_end cycle so the select changes exactly at a period boundary.
   // A stop seen mid-period is remembered and honoured at the next boundary,
   // taking priority over any slot advance due at that same boundary.
   always_comb begin
      w_stateNext    = r_state;
      w_lenNext      = r_len;
      w_loopNext     = r_loop;
      w_dwellNext    = r_dwellCnt;
      w_stopPendNext = r_stopPend;
      w_selNext      = r_sel;
      w_slotNext     = r_slotIdx;
      w_doneNext     = 1'b0;
      w_tabWe        = 1'b0;

      case (r_state)
         ST_IDLE: begin
            w_stopPendNext = 1'b0;
            w_tabWe        = i_cfg_we;
            if (i_start && !i_stop && w_lenOk) begin
               w_stateNext = ST_ARM;
               w_lenNext   = i_cfg_len;
               w_loopNext  = i_loop;
            end
         end

         ST_ARM: begin
            if (i_stop) begin
               w_stateNext = ST_IDLE;
               w_selNext   = IDLE_SEL;
               w_slotNext  = '0;
               w_doneNext  = 1'b1;
            end else if (w_periodEnd) begin
               w_stateNext = ST_RUN;
               w_selNext   = r_tabSel[0];
               w_slotNext  = '0;
               w_dwellNext = dwellEff(r_tabDwell[0]);
            end
         end

         ST_RUN: begin
            if (w_periodEnd) begin
               if (r_stopPend || i_stop) begin
                  w_stateNext    = ST_IDLE;
                  w_selNext      = IDLE_SEL;
                  w_slotNext     = '0;
                  w_doneNext     = 1'b1;
                  w_stopPendNext = 1'b0;
               end else if (r_dwellCnt > DWELL_W'(1)) begin
                  w_dwellNext = r_dwellCnt - DWELL_W'(1);
               end else if (!w_isLast) begin
                  w_selNext   = r_tabSel[w_nextIdx];
                  w_slotNext  = w_nextIdx;
                  w_dwellNext = dwellEff(r_tabDwell[w_nextIdx]);
               end else if (r_loop) begin
                  w_selNext   = r_tabSel[0];
                  w_slotNext  = '0;
                  w_dwellNext = dwellEff(r_tabDwell[0]);
               end else begin
                  w_stateNext = ST_IDLE;
                  w_selNext   = IDLE_SEL;
                  w_slotNext  = '0;
                  w_doneNext  = 1'b1;
               end
            end else if (i_stop) begin
               w_stopPendNext = 1'b1;
            end
         end

         default: begin
            w_stateNext = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_nco_wave_sequencer.sv
// ---------------------------------------------------------------------------
// tb_nco_wave_sequencer
//
// Purpose:
//    Self-checking bench for nco_wave_sequencer. A playback model expands the
//    playlist into the per-cycle output trace it must produce (arm wait up to
//    the next period boundary, then each slot for dwell*32 cycles, then the
//    done pulse), and the DUT is compared against that trace cycle by cycle.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_nco_wave_sequencer;

   localparam int         NS   = 8;
   localparam int         DW   = 16;
   localparam logic [3:0] IDLE = 4'd15;

   logic          clk_50MHz = 1'b0;
   logic          reset;
   logic          i_cfg_we;
   logic [2:0]    i_cfg_addr;
   logic [3:0]    i_cfg_sel;
   logic [DW-1:0] i_cfg_dwell;
   logic [3:0]    i_cfg_len;
   logic          i_loop;
   logic          i_start;
   logic          i_stop;
   logic [3:0]    o_signal_out;
   logic [2:0]    o_slot_idx;
   logic          o_period_end;
   logic          o_busy;
   logic          o_done;

   int total = 0;
   int bad   = 0;
   int tbCycles;

   logic [3:0] mSel   [NS];
   int         mDwell [NS];

   typedef struct {
      logic [3:0] sel;
      logic [2:0] idx;
      logic       busy;
      logic       done;
   } exp_t;

   exp_t expQ[$];

   nco_wave_sequencer #(
      .NUM_SLOTS (NS),
      .DWELL_W   (DW),
      .IDLE_SEL  (IDLE)
   ) dut (
      .clk_50MHz    (clk_50MHz),
      .reset        (reset),
      .i_cfg_we     (i_cfg_we),
      .i_cfg_addr   (i_cfg_addr),
      .i_cfg_sel    (i_cfg_sel),
      .i_cfg_dwell  (i_cfg_dwell),
      .i_cfg_len    (i_cfg_len),
      .i_loop       (i_loop),
      .i_start      (i_start),
      .i_stop       (i_stop),
      .o_signal_out (o_signal_out),
      .o_slot_idx   (o_slot_idx),
      .o_period_end (o_period_end),
      .o_busy       (o_busy),
      .o_done       (o_done)
   );

   // 50 MHz clock.
   always #10 clk_50MHz = ~clk_50MHz;

   // Clocks elapsed since reset released; modulo 32 this is the NCO address.
   always @(posedge clk_50MHz or posedge reset) begin
      if (reset) tbCycles <= 0;
      else       tbCycles <= tbCycles + 1;
   end

   // Holds reset for two cycles with all inputs idle and clears the model table.
   task automatic applyReset();
      reset       = 1'b1;
      i_cfg_we    = 1'b0;
      i_cfg_addr  = '0;
      i_cfg_sel   = '0;
      i_cfg_dwell = '0;
      i_cfg_len   = '0;
      i_loop      = 1'b0;
      i_start     = 1'b0;
      i_stop      = 1'b0;
      repeat (2) @(negedge clk_50MHz);
      reset = 1'b0;
      for (int s = 0; s < NS; s++) begin
         mSel[s]   = 4'd0;
         mDwell[s] = 0;
      end
   endtask

   // Writes one playlist slot from IDLE and records it in the model.
   task automatic writeSlot(input int addr, input int sel, input int dwell);
      i_cfg_we    = 1'b1;
      i_cfg_addr  = addr[2:0];
      i_cfg_sel   = sel[3:0];
      i_cfg_dwell = dwell[DW-1:0];
      @(negedge clk_50MHz);
      i_cfg_we    = 1'b0;
      mSel[addr]   = sel[3:0];
      mDwell[addr] = dwell;
   endtask

   // Waits (bounded) until the current cycle's phase equals ph.
   task automatic waitPhase(input int ph);
      for (int k = 0; k < 64; k++) begin
         if (tbCycles % 32 == ph) break;
         @(negedge clk_50MHz);
      end
   endtask

   // Expands the playlist into the expected per-cycle trace, starting with
   // the cycle after the start edge, when start is accepted in phase p.
   task automatic buildExpected(input int p, input int len, input bit loopEn,
                                input int passes, output int arm);
      exp_t e;
      expQ.delete();
      arm = 32 - ((p + 1) % 32);
      e = '{sel: IDLE, idx: 3'd0, busy: 1'b1, done: 1'b0};
      for (int k = 0; k < arm; k++) expQ.push_back(e);
      for (int ps = 0; ps < passes; ps++) begin
         for (int s = 0; s < len; s++) begin
            int d;
            d = (mDwell[s] == 0) ? 1 : mDwell[s];
            e = '{sel: mSel[s], idx: s[2:0], busy: 1'b1, done: 1'b0};
            for (int k = 0; k < d * 32; k++) expQ.push_back(e);
         end
      end
      if (!loopEn) begin
         expQ.push_back('{sel: IDLE, idx: 3'd0, busy: 1'b0, done: 1'b1});
         for (int k = 0; k < 3; k++)
            expQ.push_back('{sel: IDLE, idx: 3'd0, busy: 1'b0, done: 1'b0});
      end
   endtask

   // Starts a sequence in the current cycle and checks every following cycle
   // against the model trace. stopArm is a cycle index inside the arm wait,
   // stopRun and weRun are cycle offsets from the first played cycle (-1 = none).
   task automatic applyStimulus(input string name, input int len, input bit loopEn,
                                input int passes, input int stopArm, input int stopRun,
                                input int weRun);
      int p, arm, stopAt, weAt, cut;
      exp_t e;
      p = tbCycles % 32;
      buildExpected(p, len, loopEn, passes, arm);
      stopAt = -1;
      if (stopArm >= 0)      stopAt = stopArm;
      else if (stopRun >= 0) stopAt = arm + stopRun;
      weAt = (weRun >= 0) ? arm + weRun : -1;
      // A stop ends the trace: immediately in arm, else at the period's last cycle.
      if (stopAt >= 0 && stopAt < expQ.size() && expQ[stopAt].busy) begin
         cut = stopAt;
         if (stopAt >= arm)
            while (((p + 1 + cut) % 32) != 31) cut++;
         while (expQ.size() > cut + 1) void'(expQ.pop_back());
         expQ.push_back('{sel: IDLE, idx: 3'd0, busy: 1'b0, done: 1'b1});
         for (int k = 0; k < 3; k++)
            expQ.push_back('{sel: IDLE, idx: 3'd0, busy: 1'b0, done: 1'b0});
      end
      i_cfg_len = len[3:0];
      i_loop    = loopEn;
      i_start   = 1'b1;
      @(negedge clk_50MHz);
      i_start   = 1'b0;
      i_loop    = 1'b0;
      for (int i = 0; i < expQ.size(); i++) begin
         e = expQ[i];
         total++;
         if (o_signal_out !== e.sel || o_slot_idx !== e.idx ||
             o_busy !== e.busy || o_done !== e.done) begin
            bad++;
            $display("[TB] FAIL %s cycle %0d: got sel=%0d idx=%0d busy=%b done=%b, want sel=%0d idx=%0d busy=%b done=%b",
                     name, i, o_signal_out, o_slot_idx, o_busy, o_done,
                     e.sel, e.idx, e.busy, e.done);
         end
         total++;
         if (o_period_end !== (tbCycles % 32 == 31)) begin
            bad++;
            $display("[TB] FAIL %s period_end cycle %0d: got %b want %b",
                     name, i, o_period_end, (tbCycles % 32 == 31));
         end
         i_stop = (i == stopAt);
         if (i == weAt) begin
            i_cfg_we    = 1'b1;
            i_cfg_addr  = 3'd0;
            i_cfg_sel   = 4'd3;
            i_cfg_dwell = DW'(5);
         end else begin
            i_cfg_we = 1'b0;
         end
         @(negedge clk_50MHz);
      end
      i_stop   = 1'b0;
      i_cfg_we = 1'b0;
   endtask

   task automatic test_reset();
      applyReset();
      reset = 1'b1;
      #1;
      total++;
      if (o_signal_out !== IDLE || o_slot_idx !== 3'd0 || o_busy !== 1'b0 ||
          o_done !== 1'b0 || o_period_end !== 1'b0) begin
         bad++;
         $display("[TB] FAIL reset_values: got sel=%0d idx=%0d busy=%b done=%b pe=%b, want 15 0 0 0 0",
                  o_signal_out, o_slot_idx, o_busy, o_done, o_period_end);
      end
      @(negedge clk_50MHz);
      reset = 1'b0;
      // After release, period_end rises only on the 31st clock's cycle.
      for (int k = 0; k < 40; k++) begin
         total++;
         if (o_period_end !== (k % 32 == 31) || o_busy !== 1'b0 || o_signal_out !== IDLE) begin
            bad++;
            $display("[TB] FAIL reset_phase k=%0d: got pe=%b busy=%b sel=%0d, want pe=%b busy=0 sel=15",
                     k, o_period_end, o_busy, o_signal_out, (k % 32 == 31));
         end
         @(negedge clk_50MHz);
      end
   endtask

   task automatic test_oneshot();
      writeSlot(0, 0, 2);
      writeSlot(1, 5, 1);
      waitPhase(9);
      applyStimulus("oneshot", 2, 1'b0, 1, -1, -1, -1);
      waitPhase($urandom_range(0, 31));
      applyStimulus("oneshot_rand_phase", 2, 1'b0, 1, -1, -1, -1);
   endtask

   task automatic test_loop();
      writeSlot(0, 0, 2);
      writeSlot(1, 5, 1);
      waitPhase($urandom_range(0, 31));
      applyStimulus("loop", 2, 1'b1, 4, -1, 2 * 96 + 40, -1);
   endtask

   task automatic test_stop_run();
      writeSlot(0, 6, 4);
      waitPhase($urandom_range(0, 31));
      applyStimulus("stop_run", 1, 1'b0, 1, -1, 32 + 3, -1);
      waitPhase($urandom_range(0, 31));
      applyStimulus("stop_run_edge", 1, 1'b0, 1, -1, 31, -1);
   endtask

   task automatic test_stop_arm();
      writeSlot(0, 2, 1);
      waitPhase(0);
      applyStimulus("stop_arm", 1, 1'b0, 1, 3, -1, -1);
   endtask

   task automatic test_zero_dwell();
      writeSlot(0, 2, 0);
      writeSlot(1, 4, 1);
      waitPhase($urandom_range(0, 31));
      applyStimulus("zero_dwell", 2, 1'b0, 1, -1, -1, -1);
   endtask

   task automatic test_bad_len();
      int badLens[2] = '{0, 9};
      writeSlot(0, 1, 1);
      for (int b = 0; b < 2; b++) begin
         i_cfg_len = badLens[b][3:0];
         i_start   = 1'b1;
         @(negedge clk_50MHz);
         i_start   = 1'b0;
         for (int k = 0; k < 40; k++) begin
            total++;
            if (o_busy !== 1'b0 || o_done !== 1'b0 || o_signal_out !== IDLE) begin
               bad++;
               $display("[TB] FAIL bad_len len=%0d k=%0d: got busy=%b done=%b sel=%0d, want 0 0 15",
                        badLens[b], k, o_busy, o_done, o_signal_out);
            end
            @(negedge clk_50MHz);
         end
      end
   endtask

   task automatic test_start_stop_idle();
      i_cfg_len = 4'd1;
      i_start   = 1'b1;
      i_stop    = 1'b1;
      repeat (3) @(negedge clk_50MHz);
      i_start   = 1'b0;
      i_stop    = 1'b0;
      for (int k = 0; k < 40; k++) begin
         total++;
         if (o_busy !== 1'b0 || o_done !== 1'b0) begin
            bad++;
            $display("[TB] FAIL start_stop_idle k=%0d: got busy=%b done=%b, want 0 0",
                     k, o_busy, o_done);
         end
         @(negedge clk_50MHz);
      end
   endtask

   task automatic test_cfg_we_busy();
      writeSlot(0, 1, 1);
      writeSlot(1, 7, 1);
      waitPhase($urandom_range(0, 31));
      applyStimulus("cfg_we_busy", 2, 1'b1, 3, -1, 2 * 64 + 10, 10);
      waitPhase($urandom_range(0, 31));
      applyStimulus("cfg_we_replay", 2, 1'b0, 1, -1, -1, -1);
   endtask

   task automatic test_random();
      for (int it = 0; it < 5; it++) begin
         int len, runLen, stopRun, passes;
         bit loopEn;
         for (int s = 0; s < NS; s++)
            writeSlot(s, $urandom_range(0, 15), $urandom_range(0, 2));
         len    = $urandom_range(1, 8);
         loopEn = $urandom_range(0, 1);
         runLen = 0;
         for (int s = 0; s < len; s++)
            runLen += ((mDwell[s] == 0) ? 1 : mDwell[s]) * 32;
         if (loopEn) begin
            passes  = 3;
            stopRun = $urandom_range(runLen, 2 * runLen - 1);
         end else begin
            passes  = 1;
            stopRun = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, runLen - 1)) : -1;
         end
         waitPhase($urandom_range(0, 31));
         applyStimulus("random", len, loopEn, passes, -1, stopRun, -1);
      end
   endtask

   task automatic test_reset_midrun();
      writeSlot(0, 9, 3);
      i_cfg_len = 4'd1;
      i_start   = 1'b1;
      @(negedge clk_50MHz);
      i_start   = 1'b0;
      repeat (60) @(negedge clk_50MHz);
      reset = 1'b1;
      #1;
      total++;
      if (o_signal_out !== IDLE || o_slot_idx !== 3'd0 || o_busy !== 1'b0 ||
          o_done !== 1'b0 || o_period_end !== 1'b0) begin
         bad++;
         $display("[TB] FAIL reset_midrun: got sel=%0d idx=%0d busy=%b done=%b pe=%b, want 15 0 0 0 0",
                  o_signal_out, o_slot_idx, o_busy, o_done, o_period_end);
      end
      @(negedge clk_50MHz);
      reset = 1'b0;
      for (int s = 0; s < NS; s++) begin
         mSel[s]   = 4'd0;
         mDwell[s] = 0;
      end
      for (int k = 0; k < 32; k++) begin
         total++;
         if (o_period_end !== (k == 31) || o_done !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_midrun_phase k=%0d: got pe=%b done=%b, want pe=%b done=0",
                     k, o_period_end, o_done, (k == 31));
         end
         @(negedge clk_50MHz);
      end
      // The cleared table plays sel 0 for one period.
      applyStimulus("after_reset_table", 1, 1'b0, 1, -1, -1, -1);
   endtask

   initial begin
      test_reset();
      test_oneshot();
      test_loop();
      test_stop_run();
      test_stop_arm();
      test_zero_dwell();
      test_bad_len();
      test_start_stop_idle();
      test_cfg_we_busy();
      test_random();
      test_reset_midrun();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
